// File: rtl/dmi_jtag.sv
`timescale 1ns/1ps
// JTAG debug transport: IEEE 1149.1 TAP (IDCODE/DTMCS/DMIACCESS/BYPASS) bridging DMIACCESS scans onto the DMI.
// A request is raised the tck after UpdateDR and held until dmi_req_ready_i; responses are taken only in wait states.
module dmi_jtag #(
    parameter logic [31:0] IdcodeValue = 32'h0000_0001
) (
    input  logic        tck_i,
    input  logic        trst_ni,
    input  logic        tms_i,
    input  logic        td_i,
    output logic        td_o,
    output logic        tdo_oe_o,
    output logic        dmi_clear_o,
    output logic [40:0] dmi_req_o,
    output logic        dmi_req_valid_o,
    input  logic        dmi_req_ready_i,
    input  logic [33:0] dmi_resp_i,
    input  logic        dmi_resp_valid_i,
    output logic        dmi_resp_ready_o
);

    typedef enum logic [3:0] {
        TestLogicReset, RunTestIdle, SelectDrScan, CaptureDr, ShiftDr, Exit1Dr, PauseDr, Exit2Dr,
        UpdateDr, SelectIrScan, CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir, UpdateIr
    } tap_state_e;

    typedef enum logic [2:0] {Idle, Read, WaitReadValid, Write, WaitWriteValid} dmi_state_e;

    typedef struct packed {
        logic [6:0]  addr;
        logic [31:0] data;
        logic [1:0]  op;
    } dmi_dr_t;

    localparam logic [4:0] IrIdcode = 5'h01;
    localparam logic [4:0] IrDtmcs  = 5'h10;
    localparam logic [4:0] IrDmi    = 5'h11;

    tap_state_e  r_tap_state, w_tap_next;
    dmi_state_e  r_dmi_state, w_dmi_next;
    logic [4:0]  r_ir, r_ir_shift;
    logic [40:0] r_dr, w_dr_capture, w_dr_shifted;
    logic [6:0]  r_addr;
    logic [31:0] r_data;
    logic [1:0]  r_error, w_req_op, w_dmi_status;
    dmi_dr_t     w_dmi_dr;
    logic        w_sel_idcode, w_sel_dtmcs, w_sel_dmi, w_ir_path, w_dmi_busy;
    logic        w_update_dmi, w_update_dtmcs, w_capture_dmi, w_dmi_start;
    logic        w_dmi_reset, w_dmi_hardreset, w_resp_done;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) r_tap_state <= TestLogicReset;
        else          r_tap_state <= w_tap_next;
    end

    always_comb begin
        w_tap_next = r_tap_state;
        case (r_tap_state)
            TestLogicReset: w_tap_next = tms_i ? TestLogicReset : RunTestIdle;
            RunTestIdle:    w_tap_next = tms_i ? SelectDrScan   : RunTestIdle;
            SelectDrScan:   w_tap_next = tms_i ? SelectIrScan   : CaptureDr;
            CaptureDr:      w_tap_next = tms_i ? Exit1Dr        : ShiftDr;
            ShiftDr:        w_tap_next = tms_i ? Exit1Dr        : ShiftDr;
            Exit1Dr:        w_tap_next = tms_i ? UpdateDr       : PauseDr;
            PauseDr:        w_tap_next = tms_i ? Exit2Dr        : PauseDr;
            Exit2Dr:        w_tap_next = tms_i ? UpdateDr       : ShiftDr;
            UpdateDr:       w_tap_next = tms_i ? SelectDrScan   : RunTestIdle;
            SelectIrScan:   w_tap_next = tms_i ? TestLogicReset : CaptureIr;
            CaptureIr:      w_tap_next = tms_i ? Exit1Ir        : ShiftIr;
            ShiftIr:        w_tap_next = tms_i ? Exit1Ir        : ShiftIr;
            Exit1Ir:        w_tap_next = tms_i ? UpdateIr       : PauseIr;
            PauseIr:        w_tap_next = tms_i ? Exit2Ir        : PauseIr;
            Exit2Ir:        w_tap_next = tms_i ? UpdateIr       : ShiftIr;
            UpdateIr:       w_tap_next = tms_i ? SelectDrScan   : RunTestIdle;
        endcase
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_ir       <= IrIdcode;
            r_ir_shift <= 5'b00001;
        end else begin
            case (r_tap_state)
                TestLogicReset: r_ir       <= IrIdcode;
                CaptureIr:      r_ir_shift <= 5'b00001;
                ShiftIr:        r_ir_shift <= {td_i, r_ir_shift[4:1]};
                UpdateIr:       r_ir       <= r_ir_shift;
                default:        ;
            endcase
        end
    end

    assign w_sel_idcode = (r_ir == IrIdcode);
    assign w_sel_dtmcs  = (r_ir == IrDtmcs);
    assign w_sel_dmi    = (r_ir == IrDmi);
    assign w_dmi_busy   = (r_dmi_state != Idle);
    assign w_dmi_status = w_dmi_busy ? 2'b11 : r_error;
    assign w_dmi_dr     = r_dr;

    // Every DR shares one 41-bit shifter; td_i enters at the MSB of the selected register's width.
    always_comb begin
        w_dr_capture = '0;
        w_dr_shifted = {40'b0, td_i};
        if (w_sel_idcode) begin
            w_dr_capture = {9'b0, IdcodeValue};
            w_dr_shifted = {9'b0, td_i, r_dr[31:1]};
        end else if (w_sel_dtmcs) begin
            w_dr_capture = {9'b0, 14'b0, 1'b0, 1'b0, 1'b0, 3'd1, r_error, 6'd7, 4'd1};
            w_dr_shifted = {9'b0, td_i, r_dr[31:1]};
        end else if (w_sel_dmi) begin
            w_dr_capture = {r_addr, r_data, w_dmi_status};
            w_dr_shifted = {td_i, r_dr[40:1]};
        end
    end

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni)                      r_dr <= '0;
        else if (r_tap_state == CaptureDr) r_dr <= w_dr_capture;
        else if (r_tap_state == ShiftDr)   r_dr <= w_dr_shifted;
    end

    assign w_ir_path = r_tap_state inside {CaptureIr, ShiftIr, Exit1Ir, PauseIr, Exit2Ir, UpdateIr};

    always_ff @(negedge tck_i or negedge trst_ni) begin
        if (!trst_ni) td_o <= 1'b0;
        else          td_o <= w_ir_path ? r_ir_shift[0] : r_dr[0];
    end

    assign tdo_oe_o        = (r_tap_state == ShiftIr) || (r_tap_state == ShiftDr);
    assign w_update_dmi    = (r_tap_state == UpdateDr) && w_sel_dmi;
    assign w_update_dtmcs  = (r_tap_state == UpdateDr) && w_sel_dtmcs;
    assign w_capture_dmi   = (r_tap_state == CaptureDr) && w_sel_dmi;
    assign w_dmi_reset     = w_update_dtmcs && r_dr[16];
    assign w_dmi_hardreset = w_update_dtmcs && r_dr[17];
    assign w_dmi_start     = w_update_dmi && (r_error == 2'b00) && (r_dmi_state == Idle);
    assign dmi_clear_o     = w_dmi_hardreset || (r_tap_state == TestLogicReset);

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) r_dmi_state <= Idle;
        else          r_dmi_state <= w_dmi_next;
    end

    always_comb begin
        w_dmi_next       = r_dmi_state;
        dmi_req_valid_o  = 1'b0;
        dmi_resp_ready_o = 1'b0;
        w_req_op         = 2'd0;
        case (r_dmi_state)
            Idle: begin
                if (w_dmi_start && w_dmi_dr.op == 2'd1)      w_dmi_next = Read;
                else if (w_dmi_start && w_dmi_dr.op == 2'd2) w_dmi_next = Write;
            end
            Read: begin
                dmi_req_valid_o = 1'b1;
                w_req_op        = 2'd1;
                if (dmi_req_ready_i) w_dmi_next = WaitReadValid;
            end
            WaitReadValid: begin
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) w_dmi_next = Idle;
            end
            Write: begin
                dmi_req_valid_o = 1'b1;
                w_req_op        = 2'd2;
                if (dmi_req_ready_i) w_dmi_next = WaitWriteValid;
            end
            WaitWriteValid: begin
                dmi_resp_ready_o = 1'b1;
                if (dmi_resp_valid_i) w_dmi_next = Idle;
            end
            default: w_dmi_next = Idle;
        endcase
        // Hard reset abandons the transaction, so no handshake may complete on that edge.
        if (w_dmi_hardreset) begin
            w_dmi_next       = Idle;
            dmi_req_valid_o  = 1'b0;
            dmi_resp_ready_o = 1'b0;
        end
    end

    assign dmi_req_o   = {r_addr, w_req_op, r_data};
    assign w_resp_done = dmi_resp_ready_o && dmi_resp_valid_i;

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            r_addr  <= '0;
            r_data  <= '0;
            r_error <= 2'b00;
        end else begin
            if (w_dmi_start) begin
                r_addr <= w_dmi_dr.addr;
                r_data <= w_dmi_dr.data;
            end
            if (w_resp_done && r_dmi_state == WaitReadValid) r_data <= dmi_resp_i[33:2];
            if (w_resp_done && dmi_resp_i[1:0] != 2'b00 && r_error == 2'b00) r_error <= 2'b10;
            if (w_capture_dmi && w_dmi_busy) r_error <= 2'b11;
            if (w_dmi_reset || w_dmi_hardreset) r_error <= 2'b00;
        end
    end

endmodule

// File: tb/tb_dmi_jtag.sv
`timescale 1ns/1ps
// Scoreboarded bench for dmi_jtag: a JTAG driver plus DM responder feed expected scan frames and DMI
// requests into queues; independent monitors collect td_o frames and DMI handshakes and compare.
module tb_dmi_jtag;
    localparam logic [31:0] IDCODE = 32'h2495_11C3;

    logic        tck_i = 1'b0;
    logic        trst_ni, tms_i, td_i;
    logic        td_o, tdo_oe_o, dmi_clear_o;
    logic [40:0] dmi_req_o;
    logic        dmi_req_valid_o, dmi_req_ready_i;
    logic [33:0] dmi_resp_i;
    logic        dmi_resp_valid_i, dmi_resp_ready_o;

    dmi_jtag #(.IdcodeValue(IDCODE)) dut (
        .tck_i(tck_i), .trst_ni(trst_ni), .tms_i(tms_i), .td_i(td_i),
        .td_o(td_o), .tdo_oe_o(tdo_oe_o), .dmi_clear_o(dmi_clear_o),
        .dmi_req_o(dmi_req_o), .dmi_req_valid_o(dmi_req_valid_o), .dmi_req_ready_i(dmi_req_ready_i),
        .dmi_resp_i(dmi_resp_i), .dmi_resp_valid_i(dmi_resp_valid_i), .dmi_resp_ready_o(dmi_resp_ready_o)
    );

    always #10 tck_i = ~tck_i;

    typedef struct { int w; logic [40:0] v; } frame_t;
    frame_t      exp_frames[$];
    logic [40:0] exp_reqs[$];
    int          errors = 0;
    int          checks = 0;
    bit          rand_ready = 1'b0;

    // Reference model of the DTM as seen from the debugger
    logic [4:0]  m_ir;
    logic [1:0]  m_err;
    bit          m_pend, m_pend_read;
    logic [6:0]  m_addr;
    logic [31:0] m_data;

    task automatic check(input string name, input logic [40:0] act, input logic [40:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int dr_width(input logic [4:0] ir);
        case (ir)
            5'h01, 5'h10: return 32;
            5'h11:        return 41;
            default:      return 1;
        endcase
    endfunction

    task automatic model_reset();
        m_ir = 5'h01; m_err = 2'b00; m_pend = 0; m_pend_read = 0; m_addr = '0; m_data = '0;
    endtask

    task automatic step(input logic tms, input logic tdi);
        @(negedge tck_i); #1;
        tms_i = tms;
        td_i  = tdi;
    endtask

    task automatic scan_ir(input logic [4:0] ir);
        frame_t f;
        f.w = 5; f.v = 41'd1;
        exp_frames.push_back(f);
        step(1, 0); step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < 5; i++) step(i == 4, ir[i]);
        step(1, 0); step(0, 0);
        m_ir = ir;
    endtask

    task automatic scan_dr(input logic [40:0] din);
        frame_t f;
        logic   exp_clr;
        f.w = dr_width(m_ir);
        case (m_ir)
            5'h01:   f.v = 41'(IDCODE);
            5'h10:   f.v = 41'(32'h0000_1071 | (32'(m_err) << 10));
            5'h11: begin
                f.v = {m_addr, m_data, (m_pend ? 2'b11 : m_err)};
                if (m_pend) m_err = 2'b11;
            end
            default: f.v = '0;
        endcase
        exp_frames.push_back(f);
        step(1, 0); step(0, 0); step(0, 0);
        for (int i = 0; i < f.w; i++) step(i == f.w - 1, din[i]);
        step(1, 0);
        step(0, 0);
        exp_clr = (m_ir == 5'h10) && din[17];
        check("dmi_clear_at_update", 41'(dmi_clear_o), 41'(exp_clr));
        if (m_ir == 5'h10) begin
            if (din[16] || din[17]) m_err = 2'b00;
            if (din[17]) m_pend = 0;
        end
        if (m_ir == 5'h11 && m_err == 2'b00 && !m_pend) begin
            m_addr = din[40:34];
            m_data = din[33:2];
            if (din[1:0] == 2'd1 || din[1:0] == 2'd2) begin
                m_pend      = 1;
                m_pend_read = (din[1:0] == 2'd1);
                exp_reqs.push_back({m_addr, din[1:0], m_data});
            end
        end
    endtask

    task automatic respond(input logic [31:0] rdata, input logic [1:0] rc);
        int n = 0;
        do begin
            @(negedge tck_i); #2;
            n++;
        end while (!dmi_resp_ready_o && n < 300);
        checks++;
        if (!dmi_resp_ready_o) begin
            errors++;
            $display("FAIL resp_ready_wait: dmi_resp_ready_o stayed %b, expected 1", dmi_resp_ready_o);
        end
        dmi_resp_i       = {rdata, rc};
        dmi_resp_valid_i = 1'b1;
        @(negedge tck_i); #1;
        dmi_resp_valid_i = 1'b0;
        if (m_pend_read) m_data = rdata;
        if (rc != 2'b00 && m_err == 2'b00) m_err = 2'b10;
        m_pend = 0;
    endtask

    task automatic wait_accept();
        int n = 0;
        while (exp_reqs.size() != 0 && n < 300) begin
            @(negedge tck_i); #3;
            n++;
        end
        check("req_accept_wait", 41'(exp_reqs.size()), 41'd0);
    endtask

    // DM side: request acceptance
    initial begin
        dmi_req_ready_i = 1'b1;
        forever begin
            @(negedge tck_i); #1;
            dmi_req_ready_i = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor: scan frames delimited by tdo_oe_o
    initial begin : frame_mon
        int          cnt;
        logic [40:0] acc;
        frame_t      e;
        cnt = 0; acc = '0;
        forever begin
            @(negedge tck_i); #2;
            if (!trst_ni) begin
                cnt = 0; acc = '0;
            end else if (tdo_oe_o) begin
                if (cnt < 41) acc[cnt] = td_o;
                cnt++;
            end else if (cnt != 0) begin
                checks++;
                if (exp_frames.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame: got %0d bits %h, expected no frame", cnt, acc);
                end else begin
                    e = exp_frames.pop_front();
                    if (cnt != e.w || acc !== e.v) begin
                        errors++;
                        $display("FAIL scan_frame: got %0d bits %h, expected %0d bits %h", cnt, acc, e.w, e.v);
                    end
                end
                cnt = 0; acc = '0;
            end
        end
    end

    // Monitor: DMI request handshakes
    initial begin : req_mon
        logic [40:0] e;
        forever begin
            @(negedge tck_i); #2;
            if (trst_ni && dmi_req_valid_o && dmi_req_ready_i) begin
                checks++;
                if (exp_reqs.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_req: got %h, expected no request", dmi_req_o);
                end else begin
                    e = exp_reqs.pop_front();
                    if (dmi_req_o !== e) begin
                        errors++;
                        $display("FAIL dmi_req: got %h, expected %h", dmi_req_o, e);
                    end
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tms_i = 1'b1; td_i = 1'b0; trst_ni = 1'b0;
        dmi_resp_valid_i = 1'b0; dmi_resp_i = '0;
        model_reset();
        @(negedge tck_i); #2;
        check("rst_td_o", 41'(td_o), 41'd0);
        check("rst_tdo_oe", 41'(tdo_oe_o), 41'd0);
        check("rst_req_valid", 41'(dmi_req_valid_o), 41'd0);
        check("rst_resp_ready", 41'(dmi_resp_ready_o), 41'd0);
        check("rst_dmi_clear", 41'(dmi_clear_o), 41'd1);
        @(negedge tck_i); #1 trst_ni = 1'b1;
        step(0, 0);

        // IDCODE by default, then DTMCS
        scan_dr('0);
        scan_ir(5'h10);
        scan_dr('0);

        // Write to 0x10
        scan_ir(5'h11);
        scan_dr(41'h0401FFFFF06);
        check("write_req_model", exp_reqs[0], {7'h10, 2'd2, 32'h07FF_FFC1});
        wait_accept();
        respond(32'h0, 2'b00);

        // Read from 0x10, result visible in the next capture
        scan_dr(41'h04000000001);
        wait_accept();
        respond(32'h4, 2'b00);
        scan_dr({7'h10, 32'h4, 2'b00});

        // Busy capture, sticky error, dmireset
        scan_dr({7'h22, 32'h0, 2'd1});
        wait_accept();
        scan_dr('0);
        respond(32'hCAFE_0001, 2'b00);
        scan_dr('0);
        scan_ir(5'h10);
        scan_dr(41'h1_0000);
        scan_ir(5'h11);
        scan_dr({7'h05, 32'h1234_5678, 2'b00});

        // Hard reset while waiting for a response
        scan_dr({7'h33, 32'h0, 2'd1});
        wait_accept();
        scan_ir(5'h10);
        scan_dr(41'h2_0000);
        @(negedge tck_i); #2;
        check("hardreset_resp_ready", 41'(dmi_resp_ready_o), 41'd0);
        check("hardreset_clear_pulse_end", 41'(dmi_clear_o), 41'd0);
        scan_ir(5'h11);
        scan_dr({7'h05, 32'h1234_5678, 2'b00});

        // Test-Logic-Reset via TMS: IR back to IDCODE, transaction survives
        scan_dr({7'h41, 32'h0, 2'd1});
        wait_accept();
        step(1, 0); step(1, 0); step(1, 0); step(1, 0);
        check("tlr_dmi_clear", 41'(dmi_clear_o), 41'd1);
        step(0, 0);
        m_ir = 5'h01;
        scan_dr('0);
        respond(32'h0BAD_F00D, 2'b00);
        scan_ir(5'h11);
        scan_dr({7'h41, 32'h0BAD_F00D, 2'b00});

        // Randomized phase
        rand_ready = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int k;
            k = $urandom_range(0, 5);
            case (k)
                2: if (m_pend) respond($urandom, ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0);
                3: begin
                    logic [40:0] d;
                    d = {9'b0, 32'($urandom)};
                    d[16] = ($urandom_range(0, 1) == 1);
                    d[17] = ($urandom_range(0, 3) == 0);
                    if (d[17] && m_pend) wait_accept();
                    if (m_ir != 5'h10) scan_ir(5'h10);
                    scan_dr(d);
                end
                4: begin
                    logic [4:0] irs [4];
                    irs = '{5'h01, 5'h1F, 5'h00, 5'h0A};
                    scan_ir(irs[$urandom_range(0, 3)]);
                    scan_dr({9'($urandom), 32'($urandom)});
                end
                default: begin
                    if (m_ir != 5'h11) scan_ir(5'h11);
                    scan_dr({7'($urandom), 32'($urandom), 2'($urandom_range(0, 3))});
                end
            endcase
        end
        rand_ready = 1'b0;
        if (m_pend) respond($urandom, 2'b00);
        repeat (4) @(negedge tck_i);

        // Asynchronous reset mid-cycle clears DMI state
        @(negedge tck_i); #3;
        trst_ni = 1'b0;
        tms_i   = 1'b0;
        #2;
        check("arst_td_o", 41'(td_o), 41'd0);
        check("arst_tdo_oe", 41'(tdo_oe_o), 41'd0);
        check("arst_req_valid", 41'(dmi_req_valid_o), 41'd0);
        check("arst_dmi_clear", 41'(dmi_clear_o), 41'd1);
        model_reset();
        @(negedge tck_i); #1 trst_ni = 1'b1;
        step(0, 0);
        scan_ir(5'h11);
        scan_dr('0);
        repeat (4) @(negedge tck_i);

        check("frames_left", 41'(exp_frames.size()), 41'd0);
        check("reqs_left", 41'(exp_reqs.size()), 41'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
